// File: rtl/uart_ext.sv
// uart_ext: memory-mapped UART with TX/RX FIFOs, 16x-oversampled baud
// generation, 5-8 data bits, optional parity, 1/2 stop bits, sticky RX
// error flags, internal loopback and a maskable level interrupt.
module uart_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int XLEN       = 32,
  parameter int OVERSAMPLE = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stb_i,
  input  logic [2:0]      adr_i,
  input  logic [3:0]      byte_sel_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o,
  input  logic            uart_rx_i,
  output logic            uart_tx_o,
  output logic            irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  // Registers and decoded control fields
  logic [15:0] baud_q;
  logic [10:0] ctrl_q;
  logic        tx_en, rx_en, stop2, loopback, irq_rx_en, irq_tx_en, irq_err_en;
  logic [1:0]  len, parity;
  logic        par_en, par_odd;

  assign tx_en      = ctrl_q[0];
  assign rx_en      = ctrl_q[1];
  assign len        = ctrl_q[3:2];
  assign parity     = ctrl_q[5:4];
  assign stop2      = ctrl_q[6];
  assign loopback   = ctrl_q[7];
  assign irq_rx_en  = ctrl_q[8];
  assign irq_tx_en  = ctrl_q[9];
  assign irq_err_en = ctrl_q[10];
  assign par_en     = (parity == 2'b01) || (parity == 2'b10);
  assign par_odd    = (parity == 2'b10);

  logic bus_wr, bus_rd, w1c;
  assign bus_wr = stb_i & we_i;
  assign bus_rd = stb_i & ~we_i;
  assign w1c    = bus_wr && (adr_i == 3'd2) && byte_sel_i[0];

  logic unused_bits;
  assign unused_bits = ^{data_i[XLEN-1:16], byte_sel_i[3:2]};

  // Frame-length helpers shared by TX and RX
  logic [DATA_WIDTH-1:0] len_mask;
  logic [BW-1:0]         last_bit;
  assign last_bit = BW'(32'(len) + 32'd4);

  // Mask of the len+5 data bits actually carried on the line
  always_comb begin
    len_mask = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++)
      len_mask[i] = (i < (32'(len) + 32'd5));
  end

  // BAUD / CTRL register writes, honouring byte lanes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      baud_q <= '0;
      ctrl_q <= '0;
    end else if (bus_wr) begin
      if (adr_i == 3'd0) begin
        if (byte_sel_i[0]) baud_q[7:0]  <= data_i[7:0];
        if (byte_sel_i[1]) baud_q[15:8] <= data_i[15:8];
      end
      if (adr_i == 3'd1) begin
        if (byte_sel_i[0]) ctrl_q[7:0]  <= data_i[7:0];
        if (byte_sel_i[1]) ctrl_q[10:8] <= data_i[10:8];
      end
    end
  end

  // Baud tick: down-counter, tick on zero then reload; BAUD=0 halts ticks
  logic [15:0] baud_cnt;
  logic        tick;
  assign tick = (baud_cnt == 16'd0) && (baud_q != 16'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 baud_cnt <= '0;
    else if (baud_cnt == 16'd0) baud_cnt <= baud_q;
    else                       baud_cnt <= baud_cnt - 16'd1;
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]           tx_wr_ptr, tx_rd_ptr, tx_count;
  logic                  tx_full, tx_empty, tx_push, tx_pop;

  assign tx_count = tx_wr_ptr - tx_rd_ptr;
  assign tx_full  = (tx_count == (AW+1)'(FIFO_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign tx_push  = bus_wr && (adr_i == 3'd3) && byte_sel_i[0] && !tx_full;

  // TX FIFO storage
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= data_i[DATA_WIDTH-1:0];
  end

  // TX FIFO pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_e             tx_state;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [TW-1:0]         tx_tick;
  logic [BW-1:0]         tx_bit;
  logic                  tx_stop_second, tx_bit_end, tx_line, tx_busy;

  assign tx_pop     = (tx_state == TX_IDLE) && tx_en && !tx_empty;
  assign tx_bit_end = tick && (tx_tick == TW'(OVERSAMPLE - 1));
  assign tx_busy    = (tx_state != TX_IDLE);

  // TX frame sequencing; tx_en is only consulted in IDLE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state       <= TX_IDLE;
      tx_shift       <= '0;
      tx_tick        <= '0;
      tx_bit         <= '0;
      tx_stop_second <= 1'b0;
    end else begin
      if (tx_state != TX_IDLE && tick)
        tx_tick <= tx_bit_end ? '0 : tx_tick + 1'b1;
      case (tx_state)
        TX_IDLE: if (tx_pop) begin
          tx_state       <= TX_START;
          tx_shift       <= tx_mem[tx_rd_ptr[AW-1:0]] & len_mask;
          tx_tick        <= '0;
          tx_bit         <= '0;
          tx_stop_second <= 1'b0;
        end
        TX_START: if (tx_bit_end) tx_state <= TX_DATA;
        TX_DATA: if (tx_bit_end) begin
          if (tx_bit == last_bit) tx_state <= par_en ? TX_PARITY : TX_STOP;
          else                    tx_bit   <= tx_bit + 1'b1;
        end
        TX_PARITY: if (tx_bit_end) tx_state <= TX_STOP;
        TX_STOP: if (tx_bit_end) begin
          if (stop2 && !tx_stop_second) tx_stop_second <= 1'b1;
          else                          tx_state       <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // TX line level from FSM state
  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_shift[tx_bit];
      TX_PARITY: tx_line = par_odd ^ (^tx_shift);
      default:   tx_line = 1'b1;
    endcase
  end

  assign uart_tx_o = loopback ? 1'b1 : tx_line;

  // ---------------- RX input ----------------
  logic rx_meta, rx_sync, rx_prev, rx_in;
  assign rx_in = loopback ? tx_line : rx_sync;

  // Two-flop synchroniser plus previous-sample register for edge detect
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_in;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_e             rx_state;
  logic [DATA_WIDTH-1:0] rx_data;
  logic [TW-1:0]         rx_tick;
  logic [BW-1:0]         rx_bit;
  logic                  rx_half, rx_full_bit, rx_push_req, frame_set, parity_set;

  assign rx_half     = tick && (rx_tick == TW'(OVERSAMPLE/2 - 1));
  assign rx_full_bit = tick && (rx_tick == TW'(OVERSAMPLE - 1));
  assign rx_push_req = rx_en && (rx_state == RX_STOP) && rx_full_bit;
  assign frame_set   = rx_push_req && !rx_in;
  assign parity_set  = rx_en && (rx_state == RX_PARITY) && rx_full_bit &&
                       (rx_in != (par_odd ^ (^rx_data)));

  // RX frame sequencing; after the half-bit start check every sample is mid-bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state <= RX_IDLE;
      rx_data  <= '0;
      rx_tick  <= '0;
      rx_bit   <= '0;
    end else if (!rx_en) begin
      rx_state <= RX_IDLE;
      rx_tick  <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_in) begin
          rx_state <= RX_START;
          rx_tick  <= '0;
          rx_bit   <= '0;
          rx_data  <= '0;
        end
        RX_START: if (tick) begin
          if (rx_half) begin
            rx_tick  <= '0;
            rx_state <= rx_in ? RX_IDLE : RX_DATA;
          end else begin
            rx_tick <= rx_tick + 1'b1;
          end
        end
        RX_DATA: if (tick) begin
          if (rx_full_bit) begin
            rx_tick         <= '0;
            rx_data[rx_bit] <= rx_in;
            if (rx_bit == last_bit) rx_state <= par_en ? RX_PARITY : RX_STOP;
            else                    rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_tick <= rx_tick + 1'b1;
          end
        end
        RX_PARITY: if (tick) begin
          if (rx_full_bit) begin
            rx_tick  <= '0;
            rx_state <= RX_STOP;
          end else begin
            rx_tick <= rx_tick + 1'b1;
          end
        end
        RX_STOP: if (tick) begin
          if (rx_full_bit) begin
            rx_tick  <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_tick <= rx_tick + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]           rx_wr_ptr, rx_rd_ptr, rx_count;
  logic                  rx_full, rx_empty, rx_push, rx_pop, overrun_set;

  assign rx_count    = rx_wr_ptr - rx_rd_ptr;
  assign rx_full     = (rx_count == (AW+1)'(FIFO_DEPTH));
  assign rx_empty    = (rx_count == '0);
  assign rx_push     = rx_push_req && !rx_full;
  assign overrun_set = rx_push_req && rx_full;
  assign rx_pop      = bus_rd && (adr_i == 3'd3) && !rx_empty;

  // RX FIFO storage
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wr_ptr[AW-1:0]] <= rx_data;
  end

  // RX FIFO pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
    end
  end

  // Sticky error flags: a set event beats a same-cycle W1C clear
  logic frame_err, parity_err, overrun;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= frame_set   | (frame_err  & ~(w1c & data_i[5]));
      parity_err <= parity_set  | (parity_err & ~(w1c & data_i[6]));
      overrun    <= overrun_set | (overrun    & ~(w1c & data_i[7]));
    end
  end

  // Status word and read mux
  logic [15:0]     status;
  logic [XLEN-1:0] rd_val;
  assign status = {8'(rx_count), overrun, parity_err, frame_err, tx_busy,
                   rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    rd_val = '0;
    case (adr_i)
      3'd0: rd_val[15:0] = baud_q;
      3'd1: rd_val[10:0] = ctrl_q;
      3'd2: rd_val[15:0] = status;
      3'd3: if (!rx_empty) rd_val[DATA_WIDTH-1:0] = rx_mem[rx_rd_ptr[AW-1:0]];
      default: rd_val = '0;
    endcase
  end

  // Registered read data, held until the next read
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       data_o <= '0;
    else if (bus_rd) data_o <= rd_val;
  end

  // Registered interrupt request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= (irq_rx_en & ~rx_empty) | (irq_tx_en & tx_empty) |
                        (irq_err_en & (frame_err | parity_err | overrun));
  end

endmodule

// File: tb/tb_uart_ext.sv
// Self-checking bench for uart_ext: scoreboard of expected RX bytes,
// one task per scenario, direct serial drive on uart_rx_i.
module tb_uart_ext;

  localparam int BIT_CYC = 48;  // OVERSAMPLE(16) * (BAUD(2)+1)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic [2:0]  adr = '0;
  logic [3:0]  sel = '0;
  logic        we  = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] data_o;
  logic        uart_rx, uart_tx, irq;
  logic        ext_lb = 1'b0;
  logic        rx_drv = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  assign uart_rx = ext_lb ? uart_tx : rx_drv;

  always #5 clk = ~clk;

  uart_ext #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .XLEN(32), .OVERSAMPLE(16)) dut (
    .clk_i(clk), .rst_i(rst), .stb_i(stb), .adr_i(adr), .byte_sel_i(sel),
    .we_i(we), .data_i(wdata), .data_o(data_o), .uart_rx_i(uart_rx),
    .uart_tx_o(uart_tx), .irq_o(irq)
  );

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = a; wdata = d; sel = s;
    @(negedge clk);
    stb = 1'b0; we = 1'b0; sel = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = a;
    @(negedge clk);
    stb = 1'b0;
    d = data_o;
  endtask

  task automatic poll_status(input logic [31:0] mask, input logic [31:0] value,
                             input int budget, output logic ok);
    logic [31:0] st;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      bus_read(3'd2, st);
      if ((st & mask) == value) ok = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pbit, input logic stop_bit);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_drv = d[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    if (pen) begin
      rx_drv = pbit;
      repeat (BIT_CYC) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (BIT_CYC) @(negedge clk);
    rx_drv = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    #2;
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_o); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    @(negedge clk); rst = 1'b0;
    bus_read(3'd2, d);
    n_checks++; if (d !== 32'h0A) begin n_fail++; $display("FAIL reset_status got %h want 0000000a", d); end
    bus_read(3'd1, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", d); end
    bus_read(3'd5, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got %h want 0", d); end
    bus_write(3'd1, 32'h200, 4'b0011);  // irq_tx_en with empty TX FIFO
    @(negedge clk);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_tx_empty got %b want 1", irq); end
    bus_write(3'd1, 32'h0, 4'b0011);
    @(negedge clk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_tx_off got %b want 0", irq); end
    bus_write(3'd0, 32'h0000_0002, 4'b0011);
    bus_read(3'd0, d);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL baud_rw got %h want 2", d); end
  endtask

  task automatic test_loopback;
    logic [31:0] d;
    logic [7:0]  b, e;
    logic        ok;
    bus_write(3'd1, 32'h8E, 4'b0011);  // loopback, rx_en, len 8, tx off
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      bus_write(3'd3, {24'h0, b}, 4'b0001);
      exp_q.push_back(b);
    end
    bus_read(3'd2, d);
    n_checks++; if (d[1:0] !== 2'b01) begin n_fail++; $display("FAIL lb_tx_full got %b want 01", d[1:0]); end
    bus_write(3'd1, 32'h8F, 4'b0011);
    poll_status(32'hFF00, 32'h1000, 6000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL lb_rx_count_timeout got 0 want 1"); end
    bus_read(3'd2, d);
    n_checks++; if (d[3:2] !== 2'b01) begin n_fail++; $display("FAIL lb_rx_full got %b want 01", d[3:2]); end
    for (int i = 0; i < 16; i++) begin
      bus_read(3'd3, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      n_checks++; if (d !== {24'h0, e}) begin n_fail++; $display("FAIL lb_data[%0d] got %h want %h", i, d, e); end
    end
    bus_read(3'd2, d);
    n_checks++; if (d[3] !== 1'b1) begin n_fail++; $display("FAIL lb_rx_empty got %b want 1", d[3]); end
    bus_read(3'd3, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL lb_empty_read got %h want 0", d); end
  endtask

  task automatic test_len5_parity;
    logic [31:0] d;
    logic [7:0]  exp_bits;
    logic [7:0]  e;
    logic        ok;
    exp_bits = 8'b1111_1110;  // start, 5x data 1, parity 1, stop 1 (index = bit time)
    ext_lb = 1'b1;
    bus_write(3'd1, 32'h53, 4'b0011);  // tx, rx, len 5, even, stop2
    bus_write(3'd3, 32'hFF, 4'b0001);
    exp_q.push_back(8'h1F);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) ok = 1'b1;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL p5_start_timeout got 0 want 1"); end
    repeat (BIT_CYC/2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) repeat (BIT_CYC) @(negedge clk);
      n_checks++; if (uart_tx !== exp_bits[k]) begin n_fail++; $display("FAIL p5_line_bit%0d got %b want %b", k, uart_tx, exp_bits[k]); end
    end
    repeat (BIT_CYC - 2) @(negedge clk);
    bus_read(3'd2, d);  // middle of second stop bit
    n_checks++; if (d[4] !== 1'b1) begin n_fail++; $display("FAIL p5_stop2_busy got %b want 1", d[4]); end
    repeat (50) @(negedge clk);
    bus_read(3'd2, d);
    n_checks++; if (d[4] !== 1'b0) begin n_fail++; $display("FAIL p5_idle_after got %b want 0", d[4]); end
    n_checks++; if (d[3] !== 1'b0) begin n_fail++; $display("FAIL p5_rx_got got %b want 0", d[3]); end
    n_checks++; if (d[6:5] !== 2'b00) begin n_fail++; $display("FAIL p5_errs got %b want 00", d[6:5]); end
    bus_read(3'd3, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    n_checks++; if (d !== {24'h0, e}) begin n_fail++; $display("FAIL p5_data got %h want %h", d, e); end
    ext_lb = 1'b0;
  endtask

  task automatic test_frame_err;
    logic [31:0] d;
    logic [7:0]  e;
    bus_write(3'd1, 32'h40E, 4'b0011);  // rx_en, len 8, irq_err_en
    @(negedge clk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL fe_irq_before got %b want 0", irq); end
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'hA5);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL fe_irq_set got %b want 1", irq); end
    bus_read(3'd2, d);
    n_checks++; if (d[6:5] !== 2'b01) begin n_fail++; $display("FAIL fe_flags got %b want 01", d[6:5]); end
    bus_read(3'd3, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    n_checks++; if (d !== {24'h0, e}) begin n_fail++; $display("FAIL fe_data got %h want %h", d, e); end
    bus_write(3'd2, 32'h20, 4'b0001);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL fe_irq_clear_edge got %b want 1", irq); end
    @(negedge clk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL fe_irq_fall got %b want 0", irq); end
    bus_read(3'd2, d);
    n_checks++; if (d[5] !== 1'b0) begin n_fail++; $display("FAIL fe_cleared got %b want 0", d[5]); end
  endtask

  task automatic test_parity_glitch;
    logic [31:0] d;
    logic [7:0]  e;
    bus_write(3'd1, 32'h2E, 4'b0011);  // rx_en, len 8, odd parity
    send_frame(8'h0F, 8, 1'b1, 1'b0, 1'b1);  // correct odd parity would be 1
    exp_q.push_back(8'h0F);
    bus_read(3'd2, d);
    n_checks++; if (d[6:5] !== 2'b10) begin n_fail++; $display("FAIL par_flags got %b want 10", d[6:5]); end
    bus_read(3'd3, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    n_checks++; if (d !== {24'h0, e}) begin n_fail++; $display("FAIL par_data got %h want %h", d, e); end
    bus_write(3'd2, 32'h40, 4'b0001);
    @(negedge clk); rx_drv = 1'b0;
    repeat (9) @(negedge clk);  // 3 ticks, under half a bit
    rx_drv = 1'b1;
    repeat (12 * BIT_CYC) @(negedge clk);
    bus_read(3'd2, d);
    n_checks++; if (d[15:0] !== 16'h000A) begin n_fail++; $display("FAIL glitch_status got %h want 000a", d[15:0]); end
    send_frame(8'h5A, 8, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(8'h5A);
    bus_read(3'd3, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    n_checks++; if (d !== {24'h0, e}) begin n_fail++; $display("FAIL glitch_next_data got %h want %h", d, e); end
    bus_read(3'd2, d);
    n_checks++; if (d[7:5] !== 3'b000) begin n_fail++; $display("FAIL glitch_next_errs got %b want 000", d[7:5]); end
  endtask

  task automatic test_overrun_txfull;
    logic [31:0] d;
    logic [7:0]  b, e;
    logic        ok;
    bus_write(3'd1, 32'h8E, 4'b0011);
    bus_write(3'd2, 32'hE0, 4'b0001);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      bus_write(3'd3, {24'h0, b}, 4'b0001);
      exp_q.push_back(b);
    end
    bus_write(3'd3, 32'h77, 4'b0001);  // dropped: TX full
    bus_read(3'd2, d);
    n_checks++; if (d[0] !== 1'b1) begin n_fail++; $display("FAIL ov_tx_full got %b want 1", d[0]); end
    bus_write(3'd1, 32'h8F, 4'b0011);
    poll_status(32'hFF00, 32'h1000, 6000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ov_fill_timeout got 0 want 1"); end
    repeat (12 * BIT_CYC) @(negedge clk);
    bus_read(3'd2, d);  // a wrongly kept 17th byte would have caused an overrun by now
    n_checks++; if (d[7] !== 1'b0 || d[1] !== 1'b1 || d[4] !== 1'b0) begin n_fail++; $display("FAIL ov_drop17 got %h want ovr=0 tx_empty=1 busy=0", d[15:0]); end
    bus_write(3'd3, 32'h3C, 4'b0001);
    poll_status(32'h12, 32'h02, 400, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ov_tx_timeout got 0 want 1"); end
    bus_read(3'd2, d);
    n_checks++; if (d[7] !== 1'b1) begin n_fail++; $display("FAIL ov_flag got %b want 1", d[7]); end
    n_checks++; if (d[15:8] !== 8'd16) begin n_fail++; $display("FAIL ov_rx_count got %0d want 16", d[15:8]); end
    for (int i = 0; i < 16; i++) begin
      bus_read(3'd3, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      n_checks++; if (d !== {24'h0, e}) begin n_fail++; $display("FAIL ov_data[%0d] got %h want %h", i, d, e); end
    end
    bus_read(3'd2, d);
    n_checks++; if (d[3] !== 1'b1) begin n_fail++; $display("FAIL ov_rx_empty got %b want 1", d[3]); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d;
    logic        ok;
    bus_write(3'd1, 32'h0D, 4'b0011);  // tx_en, len 8, no loopback
    bus_write(3'd3, 32'h00, 4'b0001);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) ok = 1'b1;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_start_timeout got 0 want 1"); end
    repeat (3 * BIT_CYC) @(negedge clk);
    n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL rst_midframe_line got %b want 0", uart_tx); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_async_tx got %b want 1", uart_tx); end
    n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL rst_async_data got %h want 0", data_o); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    bus_read(3'd2, d);
    n_checks++; if (d !== 32'h0A) begin n_fail++; $display("FAIL rst_status got %h want 0000000a", d); end
    bus_read(3'd1, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl got %h want 0", d); end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_len5_parity;
    test_frame_err;
    test_parity_glitch;
    test_overrun_txfull;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
